// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and configuration constants.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic STOP_1      = 1'b0;
  localparam logic STOP_2      = 1'b1;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line (idle high) plus falling-edge pulse.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic line,
  output logic fall
);
  logic s1, prev;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) {prev, line, s1} <= '1;
    else       {prev, line, s1} <= {line, s1, rx_i};
  assign fall = prev & ~line;
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receiver, LSB-first frames with optional parity and 1/2 stop bits.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit as the majority of three mid-bit samples.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_UART = 8,
  parameter int DIV_SIZE  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 stop_bits_i,
  input  logic                 parity_bit_i,
  input  logic                 parity_bit_mode_i,
  input  logic [DIV_SIZE-1:0]  baud_div_i,
  input  logic                 rx_i,
  output logic [DATA_UART-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o,
  output logic                 busy_o
);
  localparam int IW = $clog2(DATA_UART);
  logic line, fall;
  uart_rx_sync u_sync (.clk_i, .rst_i, .rx_i, .line, .fall);
  state_t state, state_d;
  logic [DIV_SIZE-1:0] cnt, div_q, mid;
  logic [IW-1:0] bit_idx;
  logic [DATA_UART-1:0] shift;
  logic stop_idx, stop_q, par_q, mode_q, perr_acc, ferr_acc;
  logic tick, bit_v, last_cnt, last_stop, push;
  assign mid       = div_q >> 1;
  assign last_cnt  = cnt == div_q - DIV_SIZE'(1);
  assign last_stop = stop_q == STOP_1 || stop_idx;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s_a, s_b;
  assign tick  = cnt == mid + DIV_SIZE'(1);
  assign bit_v = (s_a & s_b) | (s_a & line) | (s_b & line);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else begin
      if (cnt == mid - DIV_SIZE'(1)) s_a <= line;
      if (cnt == mid) s_b <= line;
    end
`else
  assign tick  = cnt == mid;
  assign bit_v = line;
`endif
  assign push   = state == STOP && tick && last_stop && en_i;
  assign busy_o = state != IDLE;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (fall) state_d = START;
      START:   if (tick && bit_v) state_d = IDLE;
               else if (last_cnt) state_d = DATA;
      DATA:    if (last_cnt && bit_idx == IW'(DATA_UART - 1)) state_d = par_q ? PARITY : STOP;
      PARITY:  if (last_cnt) state_d = STOP;
      STOP:    if (tick && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!en_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt             <= '0;
      div_q           <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      stop_idx        <= 1'b0;
      stop_q          <= 1'b0;
      par_q           <= 1'b0;
      mode_q          <= 1'b0;
      perr_acc        <= 1'b0;
      ferr_acc        <= 1'b0;
      rx_data_o       <= '0;
      rx_valid_o      <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
    end else begin
      rx_valid_o <= push;
      cnt        <= (state == IDLE || state_d == IDLE || last_cnt) ? '0 : cnt + DIV_SIZE'(1);
      if (state == IDLE && state_d == START) begin
        div_q    <= baud_div_i;
        stop_q   <= stop_bits_i;
        par_q    <= parity_bit_i;
        mode_q   <= parity_bit_mode_i;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (state == DATA && tick) shift <= {bit_v, shift[DATA_UART-1:1]};
      if (state == DATA && last_cnt) bit_idx <= bit_idx + IW'(1);
      if (state == PARITY && tick) perr_acc <= bit_v != (^shift ^ (mode_q == PARITY_ODD));
      if (state == STOP && tick) ferr_acc <= ferr_acc | ~bit_v;
      if (state == STOP && last_cnt) stop_idx <= 1'b1;
      if (push) begin
        rx_data_o       <= shift;
        rx_parity_err_o <= perr_acc;
        rx_frame_err_o  <= ferr_acc | ~bit_v;
      end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frames against a scoreboard of expected pushes.
module tb_uart_rx_deserializer;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, stop_bits = 1'b0, parity_bit = 1'b0, parity_mode = 1'b0, rx = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic [7:0] rx_data;
  logic rx_valid, rx_perr, rx_ferr, busy;
  typedef struct {logic [7:0] d; logic pe; logic fe;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, n_push = 0, cyc = 0, t_edge = 0, t_push = 0;

  uart_rx_deserializer dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .stop_bits_i(stop_bits), .parity_bit_i(parity_bit),
    .parity_bit_mode_i(parity_mode), .baud_div_i(baud_div), .rx_i(rx), .rx_data_o(rx_data),
    .rx_valid_o(rx_valid), .rx_parity_err_o(rx_perr), .rx_frame_err_o(rx_ferr), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rx_valid) begin
    exp_t e;
    n_push++;
    t_push = cyc;
    if (q.size() == 0) chk("unexpected_push", 32'(rx_data), 32'hFFFF_FFFF);
    else begin
      e = q.pop_front();
      chk("data", 32'(rx_data), 32'(e.d));
      chk("parity_err", 32'(rx_perr), 32'(e.pe));
      chk("frame_err", 32'(rx_ferr), 32'(e.fe));
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int div, input bit pen, input bit podd, input bit pflip,
                      input bit st1, input bit st2, input bit two, input int gbit);
    exp_t e;
    e.d = d;
    e.pe = pen & pflip;
    e.fe = ~st1 | (two & ~st2);
    q.push_back(e);
    baud_div = 16'(div);
    parity_bit = pen;
    parity_mode = podd;
    stop_bits = two;
    rx = 1'b0;
    t_edge = cyc;
    hold(div);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == gbit) begin
        hold(div / 2 + 1);
        rx = ~d[i];
        hold(1);
        rx = d[i];
        hold(div - div / 2 - 2);
      end else hold(div);
    end
    if (pen) begin
      rx = ^d ^ podd ^ pflip;
      hold(div);
    end
    rx = st1;
    hold(div);
    if (two) begin
      rx = st2;
      hold(div);
    end
    rx = 1'b1;
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("push_timeout", 32'(q.size()), 32'd0);
    hold(4);
  endtask

  initial begin
    int p0;
    hold(2);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_perr", 32'(rx_perr), 0);
    chk("rst_ferr", 32'(rx_ferr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    en = 1'b1;
    hold(4);
    send(8'hA5, 16, 0, 0, 0, 1, 1, 0, -1);
    wait_empty(400);
    chk("latency_window", 32'((t_push - t_edge) >= 154 && (t_push - t_edge) <= 158), 1);
    send(8'h03, 16, 1, 0, 1, 1, 1, 0, -1);
    wait_empty(400);
    send(8'h03, 16, 1, 0, 0, 1, 1, 0, -1);
    wait_empty(400);
    send(8'h5A, 16, 1, 1, 0, 1, 0, 1, -1);
    wait_empty(400);
    q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    baud_div = 16'd16;
    parity_bit = 1'b0;
    stop_bits = 1'b0;
    rx = 1'b0;
    hold(16 * 12);
    rx = 1'b1;
    wait_empty(400);
    chk("break_single_push", 32'(q.size()), 0);
    p0 = n_push;
    rx = 1'b0;
    hold(3);
    rx = 1'b1;
    hold(40);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_no_push", 32'(n_push), 32'(p0));
    send(8'h81, 16, 0, 0, 0, 1, 1, 0, -1);
    wait_empty(400);
    send(8'h00, 8, 0, 0, 0, 1, 1, 0, -1);
    send(8'hFF, 8, 0, 0, 0, 1, 1, 0, -1);
    send(8'h55, 8, 0, 0, 0, 1, 1, 0, -1);
    wait_empty(400);
    p0 = n_push;
    baud_div = 16'd16;
    parity_bit = 1'b0;
    stop_bits = 1'b0;
    rx = 1'b0;
    hold(16);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      hold(16);
    end
    rx = 1'b1;
    hold(8);
    chk("abort_busy_before", 32'(busy), 1);
    en = 1'b0;
    hold(1);
    chk("abort_busy_after", 32'(busy), 0);
    hold(16 * 6);
    chk("abort_no_push", 32'(n_push), 32'(p0));
    chk("abort_data_held", 32'(rx_data), 32'h55);
    en = 1'b1;
    hold(4);
    rx = 1'b0;
    hold(16 * 3);
    chk("rst_mid_busy_before", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_data", 32'(rx_data), 0);
    chk("rst_mid_valid", 32'(rx_valid), 0);
    chk("rst_mid_errs", 32'({rx_perr, rx_ferr}), 0);
    rx = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(4);
    send(8'h3C, 16, 1, 0, 0, 1, 1, 0, -1);
    wait_empty(400);
`ifdef UART_RX_MAJORITY_VOTE_EN
    send(8'h00, 16, 0, 0, 0, 1, 1, 0, 2);
    wait_empty(400);
`endif
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
